// File: rtl/counter4_pkg.sv
// Shared definitions for the down-counter: state encoding and default width.
package counter4_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : counter4_pkg

// File: rtl/counter4_down.sv
// Loadable down-counter with expiry pulse, stop-at-zero and optional auto-reload.
module counter4_down
  import counter4_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] cap, cap_nxt;
  logic             tc_nxt;

  // State, count, captured reload value and tc registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      cap   <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      cap   <= cap_nxt;
      tc    <= tc_nxt;
    end
  end

  // Next-state logic: clr beats load, load beats counting; tc only on a real expiry.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    cap_nxt   = cap;
    tc_nxt    = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (load) begin
      cap_nxt   = load_val;
      count_nxt = load_val;
      state_nxt = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (count > WIDTH'(1)) begin
              count_nxt = count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
              tc_nxt = 1'b1;
              if (auto_reload) begin
                count_nxt = cap;
              end else begin
                count_nxt = '0;
                state_nxt = DONE;
              end
            end
          end
        end
        IDLE, DONE: begin
          count_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // Status flags are pure decodes of the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule : counter4_down

// File: tb/tb_counter4_down.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_counter4_down;
  import counter4_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: remaining count, remembered start value, mode 0=idle 1=running 2=finished.
  int m_count = 0;
  int m_cap   = 0;
  int m_mode  = 0;
  int m_tc    = 0;

  counter4_down #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic c, input logic l, input int lv, input logic e, input logic a);
    clr         = c;
    load        = l;
    load_val    = W'(lv);
    en          = e;
    auto_reload = a;
  endtask

  // Model of one clock edge, using the inputs currently applied.
  task automatic model_step();
    m_tc = 0;
    if (clr) begin
      m_count = 0;
      m_mode  = 0;
    end else if (load) begin
      m_cap   = int'(load_val);
      m_count = m_cap;
      m_mode  = (m_cap == 0) ? 0 : 1;
    end else if (m_mode == 1 && en) begin
      if (m_count == 1) begin
        m_tc = 1;
        if (auto_reload) m_count = m_cap;
        else begin
          m_count = 0;
          m_mode  = 2;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".count"}, 32'(count), 32'(m_count));
    check({where, ".busy"},  32'(busy),  32'(m_mode == 1));
    check({where, ".done"},  32'(done),  32'(m_mode == 2));
    check({where, ".tc"},    32'(tc),    32'(m_tc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    m_count = 0; m_cap = 0; m_mode = 0; m_tc = 0;
    check_outputs("arst");
    @(posedge clk);
    #1;
    check_outputs("arst_hold");
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[6];
    int ar_seq[9];
    int tc_hits;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset_hold");

    // Idle ignores enable.
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (3) cycle();

    // Load 5, one-shot countdown.
    exp_seq = '{5, 4, 3, 2, 1, 0};
    drive(1'b0, 1'b1, 5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("oneshot.seq", 32'(count), 32'(exp_seq[i]));
      check("oneshot.tc", 32'(tc), 32'(i == 5));
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    end
    check("oneshot.done", 32'(done), 32'd1);
    repeat (2) cycle();
    check("oneshot.stay", 32'(done), 32'd1);

    // Load 3 with auto-reload: period-3 tc.
    ar_seq = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
    drive(1'b0, 1'b1, 3, 1'b1, 1'b1);
    cycle();
    check("ar.first", 32'(count), 32'd3);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    tc_hits = 0;
    for (int i = 1; i < 9; i++) begin
      cycle();
      check("ar.seq", 32'(count), 32'(ar_seq[i]));
      if (tc) tc_hits++;
    end
    cycle();
    if (tc) tc_hits++;
    check("ar.tc_hits", 32'(tc_hits), 32'd3);

    // Load 4 with en toggling.
    drive(1'b0, 1'b1, 4, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 0, (i % 2) == 0, 1'b0);
      cycle();
      check("toggle.busy", 32'(busy), 32'd1);
    end
    check("toggle.count", 32'(count), 32'd2);

    // Load 6 down to 2, then clr with load; then load 0.
    drive(1'b0, 1'b1, 6, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (4) cycle();
    check("clrload.pre", 32'(count), 32'd2);
    drive(1'b1, 1'b1, 6, 1'b1, 1'b0);
    cycle();
    check("clrload.count", 32'(count), 32'd0);
    check("clrload.busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b1, 0, 1'b1, 1'b0);
    cycle();
    check("load0.busy", 32'(busy), 32'd0);

    // Load 15, run to 1, reload 9 on the expiry edge.
    drive(1'b0, 1'b1, 15, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (14) cycle();
    check("exp_load.pre", 32'(count), 32'd1);
    drive(1'b0, 1'b1, 9, 1'b1, 1'b0);
    cycle();
    check("exp_load.count", 32'(count), 32'd9);
    check("exp_load.tc", 32'(tc), 32'd0);
    check("exp_load.busy", 32'(busy), 32'd1);

    // Load 7, asynchronous reset at count 4.
    drive(1'b0, 1'b1, 7, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (3) cycle();
    check("arst.pre", 32'(count), 32'd4);
    async_reset();
    repeat (3) cycle();
    check("arst.idle", 32'(count), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 11) == 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 249) == 0) async_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_counter4_down

// File: doc/counter4_down.md
COUNTER4_DOWN -- requirements
Module: counter4_down

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: clr  input  1  synchronous clear to idle.
REQ-005 Port: load  input  1  synchronous load strobe.
REQ-006 Port: load_val  input  WIDTH  start value captured on load.
REQ-007 Port: en  input  1  count enable; decrement allowed only when high.
REQ-008 Port: auto_reload  input  1  restart from captured value on expiry instead of stopping.
REQ-009 Port: count  output  WIDTH  current count, registered.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-012 Port: done  output  1  high while in DONE.

Function
REQ-013 State machine SHALL have states IDLE, RUN and DONE.
REQ-014 Per-cycle priority SHALL be clr > load > count/expiry.
REQ-015 clr high: next count=0, state IDLE, tc=0; the captured reload value is unchanged.
REQ-016 load high with load_val!=0: next count=load_val, captured reload value=load_val, state RUN, tc=0; this applies from any state, including a load during RUN.
REQ-017 load high with load_val==0: next count=0, captured value=0, state IDLE, tc=0.
REQ-018 RUN, en=0: count and state SHALL hold; tc=0.
REQ-019 RUN, en=1, count>1: next count=count-1; tc=0.
REQ-020 RUN, en=1, count==1, auto_reload=0: next count=0, state DONE, tc=1 for exactly that next cycle.
REQ-021 RUN, en=1, count==1, auto_reload=1: next count=captured value, state stays RUN, tc=1 for exactly that next cycle.
REQ-022 Auto-reload period: tc SHALL repeat every N enabled cycles for loaded value N.
REQ-023 IDLE and DONE: count SHALL hold at 0 and en SHALL be ignored; exit only via load.
REQ-024 tc SHALL never assert in a cycle following a clr or load edge, even if the expiry condition was also true.
REQ-025 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both decoded from the state register with no input path.
REQ-026 Arithmetic: count SHALL be unsigned WIDTH bits and SHALL never wrap below 0 (no 0 -> all-ones transition).
REQ-027 auto_reload SHALL be sampled only at the expiry edge; changing it mid-count SHALL have no other effect.

Reset
REQ-028 rst high SHALL immediately force, without waiting for clk: count=0, captured value=0, state IDLE, tc=0, busy=0, done=0.
REQ-029 rst asserted mid-count SHALL abort the count.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until a load.

Structure
REQ-031 A shared package counter4_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-032 The block SHALL be a single module with no sub-module.
REQ-033 The block SHALL use one state register, one count register, one captured-value register and one registered tc.

Verification
REQ-034 Load 5, en=1, auto_reload=0: count 5,4,3,2,1,0 on successive edges; tc=1 only in the cycle count first reads 0; done=1 thereafter; busy drops with done rising.
REQ-035 Load 3, auto_reload=1, en=1 for 9 cycles: count 3,2,1,3,2,1,3,2,1; tc pulses exactly three times, period 3.
REQ-036 Load 4, toggle en 1,0,1,0: count 4,3,3,2,2; tc never asserts; busy stays 1.
REQ-037 Load 6, decrement to 2, then assert load=1 and clr=1 together: next cycle count=0, state IDLE, tc=0. Then load 0: remains IDLE, count 0, busy 0.
REQ-038 Load 15 (WIDTH=4), count to 1, then load 9 on the expiry edge: next count=9, tc=0, state RUN.
REQ-039 Load 7, assert rst asynchronously between edges at count 4: count=0, busy=0 before the next clk edge; no further change until load.
